// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: FSM states,
// instruction classes, opcode/funct constants and datapath select codes.
package mips_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_DIVW   = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   typedef enum logic [3:0] {
      C_ILL, C_ALU_R, C_ALU_I, C_LW, C_SW, C_BR, C_BRL,
      C_J, C_JAL, C_JR, C_JALR, C_DIV, C_MFHL
   } iclass_t;

   localparam logic [5:0] OP_RTYPE    = 6'b000000;
   localparam logic [5:0] OP_REGIMM   = 6'b000001;
   localparam logic [5:0] OP_J        = 6'b000010;
   localparam logic [5:0] OP_JAL      = 6'b000011;
   localparam logic [5:0] OP_BEQ      = 6'b000100;
   localparam logic [5:0] OP_BNE      = 6'b000101;
   localparam logic [5:0] OP_ADDI     = 6'b001000;
   localparam logic [5:0] OP_ANDI     = 6'b001100;
   localparam logic [5:0] OP_ORI      = 6'b001101;
   localparam logic [5:0] OP_XORI     = 6'b001110;
   localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
   localparam logic [5:0] OP_LW       = 6'b100011;
   localparam logic [5:0] OP_SW       = 6'b101011;

   localparam logic [5:0] F_MUL  = 6'b000010;
   localparam logic [5:0] F_JR   = 6'b001000;
   localparam logic [5:0] F_JALR = 6'b001001;
   localparam logic [5:0] F_MFHI = 6'b010000;
   localparam logic [5:0] F_MFLO = 6'b010010;
   localparam logic [5:0] F_DIV  = 6'b011010;
   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_XOR  = 6'b100110;
   localparam logic [5:0] F_NOR  = 6'b100111;
   localparam logic [5:0] F_SLT  = 6'b101010;

   localparam logic [4:0] RT_BGEZ   = 5'b00001;
   localparam logic [4:0] RT_BGEZAL = 5'b10001;

   localparam logic [1:0] PC_BRANCH = 2'b00;
   localparam logic [1:0] PC_JUMP   = 2'b01;
   localparam logic [1:0] PC_RS     = 2'b10;
   localparam logic [1:0] PC_PLUS1  = 2'b11;

   localparam logic [1:0] RD_RT = 2'd0;
   localparam logic [1:0] RD_RD = 2'd1;
   localparam logic [1:0] RD_RA = 2'd2;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_MEM  = 2'b01;
   localparam logic [1:0] WB_RA   = 2'b10;
   localparam logic [1:0] WB_HILO = 2'b11;

   localparam logic [2:0] ALU_ADD    = 3'b000;
   localparam logic [2:0] ALU_SUB    = 3'b001;
   localparam logic [2:0] ALU_AND    = 3'b010;
   localparam logic [2:0] ALU_OR     = 3'b100;
   localparam logic [2:0] ALU_XOR    = 3'b101;
   localparam logic [2:0] ALU_RTYPE  = 3'b110;
   localparam logic [2:0] ALU_REGIMM = 3'b111;

   function automatic logic is_link(iclass_t c);
      return (c == C_BRL) || (c == C_JAL) || (c == C_JALR);
   endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps IR fields to an instruction
// class plus the static ALU/register-destination fields used in EXEC.
module mc_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic [4:0] rt,
   output iclass_t    cls,
   output logic [2:0] op_alu,
   output logic       orig_alu,
   output logic       equal,
   output logic [1:0] reg_dst
);

   always_comb begin
      cls      = C_ILL;
      op_alu   = ALU_ADD;
      orig_alu = 1'b0;
      equal    = 1'b1;
      reg_dst  = RD_RT;
      case (opcode)
         OP_RTYPE: begin
            op_alu  = ALU_RTYPE;
            reg_dst = RD_RD;
            case (funct)
               F_ADD, F_SUB, F_AND, F_OR,
               F_XOR, F_NOR, F_SLT:  cls = C_ALU_R;
               F_JR:                 cls = C_JR;
               F_JALR: begin
                  cls     = C_JALR;
                  reg_dst = RD_RA;
               end
               F_MFHI, F_MFLO:       cls = C_MFHL;
               F_DIV:                cls = C_DIV;
               default:              cls = C_ILL;
            endcase
         end
         OP_SPECIAL2: begin
            op_alu  = ALU_RTYPE;
            reg_dst = RD_RD;
            cls     = (funct == F_MUL) ? C_ALU_R : C_ILL;
         end
         OP_REGIMM: begin
            op_alu = ALU_REGIMM;
            if (rt == RT_BGEZ) begin
               cls = C_BR;
            end else if (rt == RT_BGEZAL) begin
               cls     = C_BRL;
               reg_dst = RD_RA;
            end
         end
         OP_J:   cls = C_J;
         OP_JAL: begin
            cls     = C_JAL;
            reg_dst = RD_RA;
         end
         OP_BEQ: begin
            cls    = C_BR;
            op_alu = ALU_SUB;
         end
         OP_BNE: begin
            cls    = C_BR;
            op_alu = ALU_SUB;
            equal  = 1'b0;
         end
         OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
            cls      = C_ALU_I;
            orig_alu = 1'b1;
            op_alu   = (opcode == OP_ANDI) ? ALU_AND :
                       (opcode == OP_ORI)  ? ALU_OR  :
                       (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
         end
         OP_LW: begin
            cls      = C_LW;
            orig_alu = 1'b1;
         end
         OP_SW: begin
            cls      = C_SW;
            orig_alu = 1'b1;
         end
         default: cls = C_ILL;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM with memory handshake and divide wait.
//   state  | meaning
//   FETCH  | instruction read until mem_ready, then latch IR and PC+1
//   DECODE | classify IR; illegal goes to TRAP (or back to FETCH)
//   EXEC   | ALU op; branches/jumps resolve here and return to FETCH
//   MEM    | data read/write held until mem_ready
//   WB     | single-cycle register file write
//   DIVW   | divider busy countdown, HI/LO write at terminal count
//   TRAP   | illegal instruction, held until reset
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int DIV_CYCLES      = 32,
   parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic [4:0] rt,
   input  logic       mem_ready,
   input  logic       cond,
   output logic [1:0] pc_src,
   output logic [1:0] reg_dst,
   output logic [1:0] wb_sel,
   output logic [2:0] op_alu,
   output logic       orig_alu,
   output logic       equal,
   output logic       pc_we,
   output logic       ir_we,
   output logic       reg_we,
   output logic       mem_read,
   output logic       mem_write,
   output logic       div_start,
   output logic       hilo_we,
   output logic       illegal,
   output logic [2:0] state
);

   localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

   state_t     state_q, state_d;
   logic [5:0] cnt_q, cnt_d;

   iclass_t    cls;
   logic [2:0] dec_op_alu;
   logic       dec_orig_alu;
   logic       dec_equal;
   logic [1:0] dec_reg_dst;

   mc_decode u_decode (
      .opcode   (opcode),
      .funct    (funct),
      .rt       (rt),
      .cls      (cls),
      .op_alu   (dec_op_alu),
      .orig_alu (dec_orig_alu),
      .equal    (dec_equal),
      .reg_dst  (dec_reg_dst)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Reset gates everything to idle so FETCH's read strobe stays low in reset.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pc_src    = PC_PLUS1;
      reg_dst   = RD_RT;
      wb_sel    = WB_ALU;
      op_alu    = ALU_ADD;
      orig_alu  = 1'b0;
      equal     = 1'b1;
      pc_we     = 1'b0;
      ir_we     = 1'b0;
      reg_we    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      div_start = 1'b0;
      hilo_we   = 1'b0;
      illegal   = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               mem_read = 1'b1;
               if (mem_ready) begin
                  ir_we   = 1'b1;
                  pc_we   = 1'b1;
                  state_d = S_DECODE;
               end
            end
            S_DECODE: begin
               if (cls == C_ILL) state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
               else              state_d = S_EXEC;
            end
            S_EXEC: begin
               op_alu   = dec_op_alu;
               orig_alu = dec_orig_alu;
               equal    = dec_equal;
               reg_dst  = dec_reg_dst;
               state_d  = S_WB;
               if (is_link(cls)) begin
                  reg_we = 1'b1;
                  wb_sel = WB_RA;
               end
               case (cls)
                  C_BR, C_BRL: begin
                     pc_src  = PC_BRANCH;
                     pc_we   = ~(cond ^ dec_equal);
                     state_d = S_FETCH;
                  end
                  C_J, C_JAL: begin
                     pc_src  = PC_JUMP;
                     pc_we   = 1'b1;
                     state_d = S_FETCH;
                  end
                  C_JR, C_JALR: begin
                     pc_src  = PC_RS;
                     pc_we   = 1'b1;
                     state_d = S_FETCH;
                  end
                  C_LW, C_SW: state_d = S_MEM;
                  C_DIV: begin
                     div_start = 1'b1;
                     cnt_d     = DIV_LOAD;
                     state_d   = S_DIVW;
                  end
                  default: state_d = S_WB;
               endcase
            end
            S_MEM: begin
               mem_read  = (cls == C_LW);
               mem_write = (cls != C_LW);
               if (mem_ready) state_d = (cls == C_LW) ? S_WB : S_FETCH;
            end
            S_WB: begin
               reg_we  = 1'b1;
               wb_sel  = (cls == C_LW)   ? WB_MEM :
                         (cls == C_MFHL) ? WB_HILO : WB_ALU;
               reg_dst = (cls == C_ALU_R || cls == C_MFHL) ? RD_RD : RD_RT;
               state_d = S_FETCH;
            end
            S_DIVW: begin
               if (cnt_q == 6'd0) begin
                  hilo_we = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  cnt_d = cnt_q - 6'd1;
               end
            end
            S_TRAP:  illegal = 1'b1;
            default: state_d = S_FETCH;
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed plus randomized bench: a per-instruction cycle trace model predicts
// every output each cycle for a trapping and a non-trapping controller.
module tb_multicycle_control;
   import mips_ctrl_pkg::*;

   typedef struct packed {
      logic [2:0] st;
      logic [1:0] pc_src;
      logic [1:0] reg_dst;
      logic [1:0] wb_sel;
      logic [2:0] op_alu;
      logic       orig_alu, equal, pc_we, ir_we, reg_we;
      logic       mem_read, mem_write, div_start, hilo_we, illegal;
   } obs_t;

   typedef struct {
      logic  mr;
      obs_t  ea;
      obs_t  eb;
      string tag;
   } step_t;

   typedef enum {K_ALU_R, K_ALU_I, K_LW, K_SW, K_BR, K_BRL, K_J, K_JAL,
                 K_JR, K_JALR, K_DIV, K_MFHL, K_ILL} kind_t;

   localparam int DIVC = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode, funct;
   logic [4:0] rt;
   logic       mem_ready, cond;

   logic [1:0] a_pc_src, a_reg_dst, a_wb_sel, b_pc_src, b_reg_dst, b_wb_sel;
   logic [2:0] a_op_alu, a_state, b_op_alu, b_state;
   logic a_orig_alu, a_equal, a_pc_we, a_ir_we, a_reg_we, a_mem_read, a_mem_write;
   logic a_div_start, a_hilo_we, a_illegal;
   logic b_orig_alu, b_equal, b_pc_we, b_ir_we, b_reg_we, b_mem_read, b_mem_write;
   logic b_div_start, b_hilo_we, b_illegal;
   obs_t a_obs, b_obs;

   int checks = 0;
   int errors = 0;
   step_t q[$];

   always #5 clk = ~clk;

   multicycle_control #(.DIV_CYCLES(DIVC), .TRAP_ON_ILLEGAL(1'b1)) u_dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .rt(rt),
      .mem_ready(mem_ready), .cond(cond), .pc_src(a_pc_src), .reg_dst(a_reg_dst),
      .wb_sel(a_wb_sel), .op_alu(a_op_alu), .orig_alu(a_orig_alu), .equal(a_equal),
      .pc_we(a_pc_we), .ir_we(a_ir_we), .reg_we(a_reg_we), .mem_read(a_mem_read),
      .mem_write(a_mem_write), .div_start(a_div_start), .hilo_we(a_hilo_we),
      .illegal(a_illegal), .state(a_state));

   multicycle_control #(.DIV_CYCLES(DIVC), .TRAP_ON_ILLEGAL(1'b0)) u_nop (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .rt(rt),
      .mem_ready(mem_ready), .cond(cond), .pc_src(b_pc_src), .reg_dst(b_reg_dst),
      .wb_sel(b_wb_sel), .op_alu(b_op_alu), .orig_alu(b_orig_alu), .equal(b_equal),
      .pc_we(b_pc_we), .ir_we(b_ir_we), .reg_we(b_reg_we), .mem_read(b_mem_read),
      .mem_write(b_mem_write), .div_start(b_div_start), .hilo_we(b_hilo_we),
      .illegal(b_illegal), .state(b_state));

   assign a_obs = {a_state, a_pc_src, a_reg_dst, a_wb_sel, a_op_alu, a_orig_alu,
                   a_equal, a_pc_we, a_ir_we, a_reg_we, a_mem_read, a_mem_write,
                   a_div_start, a_hilo_we, a_illegal};
   assign b_obs = {b_state, b_pc_src, b_reg_dst, b_wb_sel, b_op_alu, b_orig_alu,
                   b_equal, b_pc_we, b_ir_we, b_reg_we, b_mem_read, b_mem_write,
                   b_div_start, b_hilo_we, b_illegal};

   function automatic obs_t idle(state_t s);
      obs_t o;
      o        = '0;
      o.st     = s;
      o.pc_src = 2'b11;
      o.equal  = 1'b1;
      return o;
   endfunction

   function automatic obs_t fetch_done();
      obs_t o;
      o          = idle(S_FETCH);
      o.mem_read = 1'b1;
      o.ir_we    = 1'b1;
      o.pc_we    = 1'b1;
      return o;
   endfunction

   function automatic kind_t classify(logic [5:0] op, logic [5:0] fn, logic [4:0] r);
      case (op)
         OP_RTYPE: begin
            if (fn inside {F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT}) return K_ALU_R;
            if (fn == F_JR)   return K_JR;
            if (fn == F_JALR) return K_JALR;
            if (fn == F_MFHI || fn == F_MFLO) return K_MFHL;
            if (fn == F_DIV)  return K_DIV;
            return K_ILL;
         end
         OP_SPECIAL2: return (fn == F_MUL) ? K_ALU_R : K_ILL;
         OP_REGIMM:   return (r == RT_BGEZ) ? K_BR : (r == RT_BGEZAL) ? K_BRL : K_ILL;
         OP_J:        return K_J;
         OP_JAL:      return K_JAL;
         OP_BEQ, OP_BNE: return K_BR;
         OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: return K_ALU_I;
         OP_LW:       return K_LW;
         OP_SW:       return K_SW;
         default:     return K_ILL;
      endcase
   endfunction

   function automatic logic [2:0] alu_code(logic [5:0] op);
      if (op == OP_RTYPE || op == OP_SPECIAL2) return 3'b110;
      if (op == OP_REGIMM) return 3'b111;
      if (op == OP_BEQ || op == OP_BNE) return 3'b001;
      if (op == OP_ANDI) return 3'b010;
      if (op == OP_ORI)  return 3'b100;
      if (op == OP_XORI) return 3'b101;
      return 3'b000;
   endfunction

   task automatic push(logic mr, obs_t ea, obs_t eb, string t);
      step_t s;
      s.mr  = mr;
      s.ea  = ea;
      s.eb  = eb;
      s.tag = t;
      q.push_back(s);
   endtask

   task automatic chk(string tag, obs_t got, obs_t exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
      end
   endtask

   // Expected cycle trace of one instruction; illegal ones stop after DECODE.
   task automatic build(logic [5:0] op, logic [5:0] fn, logic [4:0] r, logic c,
                        int fw, int mw, string t);
      kind_t k;
      obs_t  e;
      logic  link;
      k    = classify(op, fn, r);
      link = (k == K_BRL) || (k == K_JAL) || (k == K_JALR);
      for (int i = 0; i < fw; i++) begin
         e = idle(S_FETCH);
         e.mem_read = 1'b1;
         push(1'b0, e, e, {t, ":fetchwait"});
      end
      push(1'b1, fetch_done(), fetch_done(), {t, ":fetch"});
      push(1'($urandom), idle(S_DECODE), idle(S_DECODE), {t, ":decode"});
      if (k == K_ILL) return;
      e          = idle(S_EXEC);
      e.op_alu   = alu_code(op);
      e.orig_alu = op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW};
      e.equal    = (op != OP_BNE);
      e.reg_dst  = link ? 2'd2 : (op == OP_RTYPE || op == OP_SPECIAL2) ? 2'd1 : 2'd0;
      if (link) begin
         e.reg_we = 1'b1;
         e.wb_sel = 2'b10;
      end
      case (k)
         K_BR, K_BRL: begin
            e.pc_src = 2'b00;
            e.pc_we  = (c == e.equal);
         end
         K_J, K_JAL: begin
            e.pc_src = 2'b01;
            e.pc_we  = 1'b1;
         end
         K_JR, K_JALR: begin
            e.pc_src = 2'b10;
            e.pc_we  = 1'b1;
         end
         K_DIV: e.div_start = 1'b1;
         default: ;
      endcase
      push(1'($urandom), e, e, {t, ":exec"});
      case (k)
         K_BR, K_BRL, K_J, K_JAL, K_JR, K_JALR: ;
         K_LW, K_SW: begin
            for (int i = 0; i <= mw; i++) begin
               e = idle(S_MEM);
               e.mem_read  = (k == K_LW);
               e.mem_write = (k == K_SW);
               push(i == mw, e, e, {t, ":mem"});
            end
            if (k == K_LW) begin
               e = idle(S_WB);
               e.reg_we = 1'b1;
               e.wb_sel = 2'b01;
               push(1'($urandom), e, e, {t, ":wb"});
            end
         end
         K_DIV: begin
            for (int i = 0; i < DIVC; i++) begin
               e = idle(S_DIVW);
               e.hilo_we = (i == DIVC - 1);
               push(1'($urandom), e, e, {t, ":divw"});
            end
         end
         default: begin
            e = idle(S_WB);
            e.reg_we  = 1'b1;
            e.wb_sel  = (k == K_MFHL) ? 2'b11 : 2'b00;
            e.reg_dst = (k == K_ALU_R || k == K_MFHL) ? 2'd1 : 2'd0;
            push(1'($urandom), e, e, {t, ":wb"});
         end
      endcase
   endtask

   task automatic run_q();
      step_t s;
      while (q.size() > 0) begin
         s = q.pop_front();
         mem_ready = s.mr;
         @(negedge clk);
         chk({"A.", s.tag}, a_obs, s.ea);
         chk({"B.", s.tag}, b_obs, s.eb);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exec_instr(logic [5:0] op, logic [5:0] fn, logic [4:0] r, logic c,
                             int fw, int mw, string t);
      opcode = op;
      funct  = fn;
      rt     = r;
      cond   = c;
      build(op, fn, r, c, fw, mw, t);
      run_q();
   endtask

   task automatic do_reset(string t);
      rst       = 1'b1;
      mem_ready = 1'b1;
      #1;
      chk({"A.", t}, a_obs, idle(S_FETCH));
      chk({"B.", t}, b_obs, idle(S_FETCH));
      @(posedge clk);
      #1;
      chk({"A.", t, "_hold"}, a_obs, idle(S_FETCH));
      chk({"B.", t, "_hold"}, b_obs, idle(S_FETCH));
      rst = 1'b0;
   endtask

   logic [11:0] legal [16] = '{
      {OP_RTYPE, F_ADD}, {OP_RTYPE, F_SUB}, {OP_RTYPE, F_SLT}, {OP_RTYPE, F_JR},
      {OP_RTYPE, F_JALR}, {OP_RTYPE, F_MFHI}, {OP_RTYPE, F_MFLO}, {OP_RTYPE, F_DIV},
      {OP_SPECIAL2, F_MUL}, {OP_REGIMM, 6'd0}, {OP_J, 6'd0}, {OP_JAL, 6'd0},
      {OP_BEQ, 6'd0}, {OP_BNE, 6'd0}, {OP_ORI, 6'd0}, {OP_LW, 6'd0}};

   initial begin
      logic [11:0] ent;
      logic [5:0]  rop, rfn;
      logic [4:0]  rrt;
      obs_t        ta, tb;

      rst = 1'b1;
      opcode = '0;
      funct = '0;
      rt = '0;
      cond = 1'b0;
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      do_reset("reset");

      exec_instr(OP_ADDI, 6'h15, 5'd3, 1'b0, 0, 0, "addi");
      exec_instr(OP_LW, 6'h00, 5'd4, 1'b0, 0, 3, "lw_wait3");
      exec_instr(OP_BNE, 6'h00, 5'd1, 1'b1, 0, 0, "bne_c1");
      exec_instr(OP_BNE, 6'h00, 5'd1, 1'b0, 0, 0, "bne_c0");
      exec_instr(OP_BEQ, 6'h00, 5'd1, 1'b1, 1, 0, "beq_c1");
      exec_instr(OP_RTYPE, F_DIV, 5'd2, 1'b0, 0, 0, "div");
      exec_instr(OP_RTYPE, F_MFLO, 5'd0, 1'b0, 0, 0, "mflo");
      exec_instr(OP_SW, 6'h3f, 5'd7, 1'b0, 2, 1, "sw");
      exec_instr(OP_JAL, 6'h00, 5'd0, 1'b0, 0, 0, "jal");
      exec_instr(OP_RTYPE, F_JR, 5'd0, 1'b0, 0, 0, "jr");
      exec_instr(OP_REGIMM, 6'h00, RT_BGEZAL, 1'b0, 0, 0, "bgezal_c0");
      exec_instr(OP_XORI, 6'h00, 5'd9, 1'b0, 0, 0, "xori");

      // Illegal opcode: trapping controller sticks in TRAP, the other keeps refetching.
      opcode = 6'b111111;
      funct  = 6'h00;
      rt     = 5'd0;
      build(6'b111111, 6'h00, 5'd0, 1'b0, 0, 0, "illegal");
      ta = idle(S_TRAP);
      ta.illegal = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tb = (i % 2 == 0) ? fetch_done() : idle(S_DECODE);
         push(1'b1, ta, tb, "illegal:post");
      end
      run_q();
      do_reset("reset_after_trap");

      // Reset in the second DIVW cycle (counter = 2) must abort the divide.
      opcode = OP_RTYPE;
      funct  = F_DIV;
      rt     = 5'd0;
      cond   = 1'b0;
      build(OP_RTYPE, F_DIV, 5'd0, 1'b0, 0, 0, "div_abort");
      for (int i = 0; i < 3; i++) void'(q.pop_back());
      run_q();
      chk("A.div_abort:divw2", a_obs, idle(S_DIVW));
      chk("B.div_abort:divw2", b_obs, idle(S_DIVW));
      #2;
      do_reset("reset_mid_divw");
      exec_instr(OP_ADDI, 6'h00, 5'd1, 1'b0, 0, 0, "addi_after_rst");

      for (int n = 0; n < 60; n++) begin
         ent = legal[$urandom_range(0, 15)];
         rop = ent[11:6];
         rfn = ent[5:0];
         rrt = 5'($urandom);
         if (rop != OP_RTYPE && rop != OP_SPECIAL2) rfn = 6'($urandom);
         if (rop == OP_REGIMM) rrt = ($urandom_range(0, 1) != 0) ? RT_BGEZ : RT_BGEZAL;
         exec_instr(rop, rfn, rrt, 1'($urandom), $urandom_range(0, 2),
                    $urandom_range(0, 3), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter DIV_CYCLES, default 32, SHALL set divide busy cycles (legal range 1..64).
REQ-002 Parameter TRAP_ON_ILLEGAL, default 1, SHALL select the illegal-opcode response: 1 = trap, 0 = execute as NOP.
REQ-003 Port clk, in, 1, SHALL be the sole clock; all state updates on rising edge.
REQ-004 Port rst, in, 1, SHALL be the asynchronous active-high reset.
REQ-005 Port opcode, in, 6, instr[31:26]; funct, in, 6, instr[5:0]; rt, in, 5, instr[20:16]; all sampled from the datapath IR.
REQ-006 Port mem_ready, in, 1, SHALL be the memory completion handshake.
REQ-007 Port cond, in, 1, SHALL be the ALU branch condition (zero for BEQ/BNE, sign-clear for BGEZ/BGEZAL).
REQ-008 Port pc_src, out, 2: 00 branch target, 01 jump target, 10 rs, 11 PC+1.
REQ-009 Port reg_dst, out, 2: 0 rt, 1 rd, 2 $ra.
REQ-010 Port wb_sel, out, 2: 00 ALU, 01 memory, 10 return address, 11 HI/LO.
REQ-011 Ports op_alu (out, 3), orig_alu (out, 1; 1 = immediate) and equal (out, 1; 1 = BEQ sense).
REQ-012 Ports pc_we, ir_we, reg_we, mem_read, mem_write, div_start, hilo_we, illegal: out, 1 each.
REQ-013 Port state, out, 3, SHALL expose the current FSM state.

Function
REQ-014 States SHALL be FETCH, DECODE, EXEC, MEM, WB, DIVW and TRAP.
REQ-015 Idle output values: all enables 0, pc_src=11, reg_dst=0, wb_sel=00, op_alu=000, orig_alu=0, equal=1; any output not listed for a state SHALL hold its idle value.
REQ-016 FETCH: mem_read=1 until mem_ready; in the mem_ready cycle ir_we=1, pc_we=1, pc_src=11; next state DECODE.
REQ-017 DECODE: 1 cycle. Unknown opcode/funct goes to TRAP if TRAP_ON_ILLEGAL=1, else FETCH. All other instructions go to EXEC.
REQ-018 EXEC: op_alu, orig_alu, equal and reg_dst SHALL be driven per instruction, using the existing encodings (ADDI/LW/SW 000, BEQ/BNE 001, ANDI 010, ORI 100, XORI 101, REGIMM 111, R-type 110).
REQ-019 EXEC, branches: pc_src=00; pc_we = (cond XNOR equal), with equal=1 for BGEZ/BGEZAL. BGEZAL: reg_we=1, reg_dst=2, wb_sel=10, unconditionally. Next state FETCH.
REQ-020 EXEC, J/JAL: pc_src=01, pc_we=1. JR/JALR: pc_src=10, pc_we=1. JAL/JALR also assert reg_we=1, reg_dst=2, wb_sel=10. Next state FETCH.
REQ-021 EXEC transitions: LW/SW go to MEM. DIV pulses div_start for 1 cycle and goes to DIVW. All other instructions go to WB.
REQ-022 MEM: mem_read=1 (LW) or mem_write=1 (SW), held until mem_ready. On mem_ready, LW goes to WB and SW goes to FETCH.
REQ-023 WB: reg_we=1 for exactly 1 cycle. wb_sel: 01 for LW, 11 for MFHI/MFLO, else 00. reg_dst: 1 for R-type/MUL, 0 for I-type. Next state FETCH.
REQ-024 DIVW: a 6-bit counter loads DIV_CYCLES-1 on entry and decrements each cycle. At 0: hilo_we=1 for 1 cycle, then FETCH.
REQ-025 TRAP: illegal=1 and all enables 0; TRAP is held until rst.
REQ-026 With mem_ready held high, latency SHALL be: branch/jump 3 cycles, R-type/I-type/SW 4, LW 5, DIV 3+DIV_CYCLES.
REQ-027 mem_ready outside FETCH/MEM SHALL be ignored. A mem_ready already high on FETCH entry completes FETCH in that same cycle.
REQ-028 Outputs SHALL be a combinational function of the registered state and the IR fields only, with no dependence on mem_ready except for ir_we/pc_we in FETCH and the MEM exit.

Reset
REQ-029 rst asserted SHALL asynchronously force state=FETCH, counter=0 and all enables to 0 (idle values), including mid-MEM or mid-DIVW.
REQ-030 The first fetch SHALL start on the first rising clk after rst deasserts.

Structure
REQ-031 Package mips_ctrl_pkg SHALL hold the state enum, the opcode/funct constants and the pc_src/reg_dst/wb_sel/op_alu encodings.
REQ-032 Sub-module mc_decode (combinational) SHALL map opcode/funct/rt to an instruction class plus static EXEC fields; the FSM SHALL be in multicycle_control.

Verification
REQ-033 ADDI, mem_ready=1 -> states FETCH,DECODE,EXEC,WB; reg_we=1 only in cycle 4 with reg_dst=0, wb_sel=00; op_alu=000, orig_alu=1 in EXEC.
REQ-034 LW, mem_ready low for 3 MEM cycles -> mem_read held 4 MEM cycles; WB with wb_sel=01; total 8 cycles.
REQ-035 BNE: cond=1 gives pc_we=0 in EXEC; cond=0 gives pc_we=1 with pc_src=00.
REQ-036 DIV with DIV_CYCLES=4 -> div_start 1 pulse, 4 DIVW cycles, hilo_we only in the 4th; then MFLO WB has wb_sel=11.
REQ-037 Opcode 6'b111111 -> TRAP with illegal=1 held; with TRAP_ON_ILLEGAL=0 -> FETCH after DECODE, no enables.
REQ-038 rst pulsed mid-DIVW (counter=2) -> immediate FETCH, hilo_we never asserted, FETCH restarts after release.
